// File: rtl/price_epoch_sequencer.sv
// Price-change sequencer: turns a streaming 4-asset price vector into engine launches and forwards orders downstream.
// Optional feature: define SEQ_TIMEOUT_EN to abort a stalled engine after TIMEOUT_CYCLES and raise a sticky timeout_err.
module price_epoch_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_100mhz,
    input  logic              global_reset,
    input  logic [0:3][15:0]  latest_price,
    input  logic              latest_price_valid,
    output logic [0:3][15:0]  eng_price,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic              eng_order_valid,
    input  logic [71:0]       eng_order,
    output logic [71:0]       bus,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              busy,
    output logic [15:0]       dropped_cnt,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ENG = 2'd2,
        EMIT     = 2'd3
    } state_t;

    state_t             state_reg;
    logic               pending_reg;
    logic               first_reg;
    logic [0:3][15:0]   prev_price_reg;
    logic [3:0]         asset_diff;
    logic               price_event;
    logic [0:3][15:0]   capture_price;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_diff
            assign asset_diff[gi] = (latest_price[gi] != prev_price_reg[gi]);
        end
    endgenerate

    assign price_event = latest_price_valid && (first_reg || (|asset_diff));

    // A pending launch uses the most recent valid price, which is the live input when it is valid this cycle.
    assign capture_price = latest_price_valid ? latest_price : prev_price_reg;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_reg;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk_100mhz or posedge global_reset) begin
        if (global_reset) begin
            state_reg      <= IDLE;
            pending_reg    <= 1'b0;
            first_reg      <= 1'b1;
            prev_price_reg <= '0;
            eng_price      <= '0;
            eng_start      <= 1'b0;
            bus            <= '0;
            bus_valid      <= 1'b0;
            busy           <= 1'b0;
            dropped_cnt    <= '0;
`ifdef SEQ_TIMEOUT_EN
            timer_reg      <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            if (latest_price_valid) begin
                prev_price_reg <= latest_price;
                first_reg      <= 1'b0;
            end

            eng_start <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A same-cycle event while pending is folded into this single capture.
                    if (price_event || pending_reg) begin
                        eng_price   <= capture_price;
                        pending_reg <= 1'b0;
                        state_reg   <= LAUNCH;
                        busy        <= 1'b1;
                    end
                end

                LAUNCH: begin
                    eng_start <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    timer_reg <= '0;
`endif
                    state_reg <= WAIT_ENG;
                end

                WAIT_ENG: begin
                    if (eng_done) begin
                        if (eng_order_valid) begin
                            bus       <= eng_order;
                            bus_valid <= 1'b1;
                            state_reg <= EMIT;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
`ifdef SEQ_TIMEOUT_EN
                    end else if (timer_reg == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
`endif
                    end
                end

                EMIT: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase

            // Events arriving mid-epoch coalesce into one pending slot; extras are counted as dropped.
            if (state_reg != IDLE && price_event) begin
                if (!pending_reg) begin
                    pending_reg <= 1'b1;
                end else if (dropped_cnt != 16'hFFFF) begin
                    dropped_cnt <= dropped_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_price_epoch_sequencer.sv
// Directed bench for price_epoch_sequencer: launch timing, order emit, coalescing, timeout and async reset.
module tb_price_epoch_sequencer;

    logic              clk_100mhz = 1'b0;
    logic              global_reset;
    logic [0:3][15:0]  latest_price;
    logic              latest_price_valid;
    logic [0:3][15:0]  eng_price;
    logic              eng_start;
    logic              eng_done;
    logic              eng_order_valid;
    logic [71:0]       eng_order;
    logic [71:0]       bus;
    logic              bus_valid;
    logic              bus_ready;
    logic              busy;
    logic [15:0]       dropped_cnt;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    localparam logic [0:3][15:0] P1 = {16'h6400, 16'h2800, 16'h3200, 16'h3C00};
    localparam logic [0:3][15:0] P2 = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    localparam logic [0:3][15:0] P3 = {16'h0100, 16'h0200, 16'h0300, 16'h0401};
    localparam logic [0:3][15:0] P4 = {16'hFF00, 16'h0200, 16'h0300, 16'h0401};
    localparam logic [0:3][15:0] P5 = {16'hFF00, 16'h7FFF, 16'h8000, 16'h0001};
    localparam logic [0:3][15:0] P6 = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    localparam logic [71:0] ORD1 = 72'hA5_0000_0000_0000_0001;
    localparam logic [71:0] ORD2 = 72'h3C_DEAD_BEEF_0000_0042;

    price_epoch_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk_100mhz         (clk_100mhz),
        .global_reset       (global_reset),
        .latest_price       (latest_price),
        .latest_price_valid (latest_price_valid),
        .eng_price          (eng_price),
        .eng_start          (eng_start),
        .eng_done           (eng_done),
        .eng_order_valid    (eng_order_valid),
        .eng_order          (eng_order),
        .bus                (bus),
        .bus_valid          (bus_valid),
        .bus_ready          (bus_ready),
        .busy               (busy),
        .dropped_cnt        (dropped_cnt),
        .timeout_err        (timeout_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end else begin
            $display("chk  %s got %h ok", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    initial begin
        global_reset       = 1'b1;
        latest_price       = '0;
        latest_price_valid = 1'b0;
        eng_done           = 1'b0;
        eng_order_valid    = 1'b0;
        eng_order          = '0;
        bus_ready          = 1'b0;
        tick();
        tick();
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_start", 72'(eng_start), 72'd0);
        chk("rst_bus_valid", 72'(bus_valid), 72'd0);
        chk("rst_bus", bus, 72'd0);
        chk("rst_eng_price", 72'(eng_price), 72'd0);
        chk("rst_dropped", 72'(dropped_cnt), 72'd0);
        chk("rst_timeout", 72'(timeout_err), 72'd0);
        global_reset = 1'b0;
        tick();
        chk("idle_no_valid", 72'(busy), 72'd0);

        // First valid price after reset launches two edges later.
        latest_price       = P1;
        latest_price_valid = 1'b1;
        tick();
        chk("cap_start_lo", 72'(eng_start), 72'd0);
        chk("cap_eng_price", 72'(eng_price), 72'(P1));
        chk("cap_busy", 72'(busy), 72'd1);
        tick();
        chk("launch_start", 72'(eng_start), 72'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("const_no_start", 72'(eng_start), 72'd0);
        end
        chk("const_dropped", 72'(dropped_cnt), 72'd0);

        // Valid order held by slow downstream.
        eng_done        = 1'b1;
        eng_order_valid = 1'b1;
        eng_order       = ORD1;
        tick();
        eng_done        = 1'b0;
        eng_order_valid = 1'b0;
        eng_order       = '0;
        chk("emit_valid", 72'(bus_valid), 72'd1);
        chk("emit_bus", bus, ORD1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 72'(bus_valid), 72'd1);
            chk("hold_bus", bus, ORD1);
        end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        chk("hs_valid_drop", 72'(bus_valid), 72'd0);
        chk("hs_busy", 72'(busy), 72'd0);

        // Stray engine completion in IDLE has no effect.
        eng_done        = 1'b1;
        eng_order_valid = 1'b1;
        eng_order       = ORD2;
        tick();
        eng_done        = 1'b0;
        eng_order_valid = 1'b0;
        chk("stray_valid", 72'(bus_valid), 72'd0);
        chk("stray_bus", bus, ORD1);
        chk("stray_busy", 72'(busy), 72'd0);

        // Three changes during WAIT_ENG: one pending, two dropped.
        latest_price = P2;
        tick();
        chk("p2_eng_price", 72'(eng_price), 72'(P2));
        tick();
        chk("p2_start", 72'(eng_start), 72'd1);
        latest_price = P3;
        tick();
        latest_price = P4;
        tick();
        latest_price = P5;
        tick();
        chk("coal_dropped", 72'(dropped_cnt), 72'd2);
        chk("coal_eng_price", 72'(eng_price), 72'(P2));
        eng_done        = 1'b1;
        eng_order_valid = 1'b0;
        tick();
        eng_done = 1'b0;
        chk("noord_valid", 72'(bus_valid), 72'd0);
        chk("noord_busy", 72'(busy), 72'd0);
        tick();
        chk("pend_busy", 72'(busy), 72'd1);
        chk("pend_eng_price", 72'(eng_price), 72'(P5));
        tick();
        chk("pend_start", 72'(eng_start), 72'd1);

        // Engine never answers.
        for (int i = 0; i < 15; i++) tick();
        chk("to_before_err", 72'(timeout_err), 72'd0);
        chk("to_before_busy", 72'(busy), 72'd1);
        tick();
`ifdef SEQ_TIMEOUT_EN
        chk("to_err", 72'(timeout_err), 72'd1);
        chk("to_idle", 72'(busy), 72'd0);
`else
        chk("noto_err", 72'(timeout_err), 72'd0);
        chk("noto_busy", 72'(busy), 72'd1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("noto_release", 72'(busy), 72'd0);
`endif
        latest_price = P6;
        tick();
        chk("p6_eng_price", 72'(eng_price), 72'(P6));
        tick();
        chk("p6_start", 72'(eng_start), 72'd1);

        // Reset in the middle of EMIT.
        eng_done        = 1'b1;
        eng_order_valid = 1'b1;
        eng_order       = ORD2;
        tick();
        eng_done        = 1'b0;
        eng_order_valid = 1'b0;
        chk("emit2_valid", 72'(bus_valid), 72'd1);
        chk("emit2_bus", bus, ORD2);
        #3;
        global_reset = 1'b1;
        #1;
        chk("arst_valid", 72'(bus_valid), 72'd0);
        chk("arst_busy", 72'(busy), 72'd0);
        chk("arst_dropped", 72'(dropped_cnt), 72'd0);
        chk("arst_bus", bus, 72'd0);
        tick();
        global_reset = 1'b0;
        tick();
        chk("post_rst_eng_price", 72'(eng_price), 72'(P6));
        chk("post_rst_busy", 72'(busy), 72'd1);
        tick();
        chk("post_rst_start", 72'(eng_start), 72'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/price_epoch_sequencer.md
PRICE_EPOCH_SEQUENCER -- requirements
Module: price_epoch_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: one clock; reset is asynchronous and active-high.
REQ-002 Parameter: TIMEOUT_CYCLES, 1024, max WAIT_ENG cycles before abort (>=2).
REQ-003 Port: clk_100mhz  in  1  system clock, all logic on rising edge.
REQ-004 Port: global_reset  in  1  async active-high reset.
REQ-005 Port: latest_price  in  4x16  signed Q8.8 per-asset price vector [0:3].
REQ-006 Port: latest_price_valid  in  1  latest_price qualifier.
REQ-007 Port: eng_price  out  4x16  registered price snapshot to strategy engine.
REQ-008 Port: eng_start  out  1  one-cycle engine launch pulse.
REQ-009 Port: eng_done  in  1  engine completion pulse.
REQ-010 Port: eng_order_valid  in  1  engine produced an order, sampled with eng_done.
REQ-011 Port: eng_order  in  72  order word, sampled with eng_done.
REQ-012 Port: bus  out  72  registered order word to downstream.
REQ-013 Port: bus_valid  out  1  bus holds a valid order.
REQ-014 Port: bus_ready  in  1  downstream accepts order.
REQ-015 Port: busy  out  1  high whenever state != IDLE.
REQ-016 Port: dropped_cnt  out  16  saturating count of coalesced price events.
REQ-017 Port: timeout_err  out  1  sticky engine-timeout flag.

Function
REQ-018 Price event SHALL be: latest_price_valid && (first valid since reset || latest_price != prev_price); prev_price loads latest_price on every valid cycle.
REQ-019 States SHALL be IDLE, LAUNCH, WAIT_ENG, EMIT.
REQ-020 IDLE: on event or pending=1, eng_price <= latest_price (latest value wins), pending <= 0, -> LAUNCH next cycle.
REQ-021 LAUNCH: eng_start=1 for exactly one cycle, timer <= 0, -> WAIT_ENG.
REQ-022 WAIT_ENG: timer increments; eng_done&&eng_order_valid -> bus <= eng_order, -> EMIT; eng_done&&!eng_order_valid -> IDLE.
REQ-023 EMIT: bus_valid=1, bus stable until bus_valid&&bus_ready; handshake cycle -> IDLE.
REQ-024 Event while state != IDLE: pending=0 -> pending <= 1; pending=1 -> dropped_cnt+1, saturating at 0xFFFF.
REQ-025 Event in same cycle as IDLE capture from pending SHALL be absorbed by that capture, no drop counted.
REQ-026 Event-to-eng_start latency SHALL be 2 cycles from IDLE; eng_done-to-bus_valid latency 1 cycle.
REQ-027 eng_done outside WAIT_ENG SHALL be ignored.
REQ-028 eng_price SHALL change only on IDLE capture; bus only on WAIT_ENG completion.

Reset
REQ-029 global_reset SHALL immediately force state IDLE, eng_price 0, eng_start 0, bus 0, bus_valid 0, busy 0, dropped_cnt 0, timeout_err 0, pending 0, prev_price 0, first-flag set.
REQ-030 Reset mid-EMIT SHALL drop bus_valid asynchronously; order lost, not replayed.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: in WAIT_ENG, timer == TIMEOUT_CYCLES-1 without eng_done -> timeout_err <= 1 (sticky until reset), -> IDLE; eng_done in that cycle wins.
REQ-032 Macro SEQ_TIMEOUT_EN undefined: no timer logic, WAIT_ENG waits indefinitely, timeout_err tied 0.

Verification
REQ-033 Reset, then price {0x6400,0x2800,0x3200,0x3C00} valid held -> single eng_start 2 cycles later, eng_price equals vector, no further starts while constant.
REQ-034 eng_done+eng_order_valid, eng_order=72'hA5_0000_0000_0000_0001, bus_ready low 5 cycles -> bus_valid high, bus stable 5 cycles, drops cycle after bus_ready.
REQ-035 While WAIT_ENG, apply 3 distinct price changes -> pending set, dropped_cnt=2, next eng_price equals third vector.
REQ-036 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no eng_done -> timeout_err=1 at cycle 16 of WAIT_ENG, state IDLE, next event relaunches.
REQ-037 eng_done with eng_order_valid=0 -> no bus_valid, busy low next cycle.
REQ-038 Assert global_reset during EMIT -> bus_valid, busy, dropped_cnt 0 same cycle; first valid after release triggers launch.
